reg_read_scoreboard: RTL and testbench

- Read-side companion to the general register file.
- Sits in the decode stage and tracks every in-flight register write in E, M and W.
- Decides per cycle whether the decode instruction must stall, and supplies the correct rs/rt operand values by choosing between register-file read data and forwarded stage results.
- Also counts stall cycles for performance debug.

---
 rtl/reg_read_scoreboard_if.sv | 45 ++++
 rtl/reg_read_scoreboard.sv | 122 ++++++++++++
 tb/tb_reg_read_scoreboard.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_read_scoreboard_if.sv
// +------------------------------------------------------------------+
// | reg_read_scoreboard_if : decode-side bundle of the read scoreboard|
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface reg_read_scoreboard_if #(
  parameter int CNTW = 32
);
  logic            freeze;
  logic            issue;
  logic [4:0]      issue_a3;
  logic [1:0]      issue_tnew;
  logic [4:0]      rs_addr;
  logic [4:0]      rt_addr;
  logic [1:0]      rs_tuse;
  logic [1:0]      rt_tuse;
  logic            rs_used;
  logic            rt_used;
  logic [31:0]     grf_r1;
  logic [31:0]     grf_r2;
  logic [31:0]     fwd_e;
  logic [31:0]     fwd_m;
  logic [31:0]     fwd_w;
  logic            stall;
  logic [31:0]     rs_val;
  logic [31:0]     rt_val;
  logic [CNTW-1:0] stall_count;

  modport master (
    output freeze, issue, issue_a3, issue_tnew,
    output rs_addr, rt_addr, rs_tuse, rt_tuse, rs_used, rt_used,
    output grf_r1, grf_r2, fwd_e, fwd_m, fwd_w,
    input  stall, rs_val, rt_val, stall_count
  );

  modport slave (
    input  freeze, issue, issue_a3, issue_tnew,
    input  rs_addr, rt_addr, rs_tuse, rt_tuse, rs_used, rt_used,
    input  grf_r1, grf_r2, fwd_e, fwd_m, fwd_w,
    output stall, rs_val, rt_val, stall_count
  );
endinterface

`default_nettype wire

// File: rtl/reg_read_scoreboard.sv
// +------------------------------------------------------------------+
// | reg_read_scoreboard : E/M/W write tracking, stall + operand fwd   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module reg_read_scoreboard #(
  parameter int NSTAGE = 3,
  parameter int CNTW   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  reg_read_scoreboard_if.slave  bus
);

  localparam int NSRC = 2;

  // Slot 0 is E (youngest), NSTAGE-1 is W (oldest).
  logic [NSTAGE-1:0] slot_valid;
  logic [4:0]        slot_a3   [NSTAGE];
  logic [1:0]        slot_tnew [NSTAGE];
  logic [31:0]       stage_data[NSTAGE];

  logic [4:0]        src_addr  [NSRC];
  logic              src_used  [NSRC];
  logic [1:0]        src_tuse  [NSRC];
  logic [31:0]       src_grf   [NSRC];
  logic              src_stall [NSRC];
  logic [31:0]       src_val   [NSRC];

  logic              stall;
  logic [CNTW-1:0]   stall_cnt;

  assign stage_data[0] = bus.fwd_e;
  assign stage_data[1] = bus.fwd_m;
  assign stage_data[2] = bus.fwd_w;

  assign src_addr[0] = bus.rs_addr;
  assign src_addr[1] = bus.rt_addr;
  assign src_used[0] = bus.rs_used;
  assign src_used[1] = bus.rt_used;
  assign src_tuse[0] = bus.rs_tuse;
  assign src_tuse[1] = bus.rt_tuse;
  assign src_grf[0]  = bus.grf_r1;
  assign src_grf[1]  = bus.grf_r2;

  generate
    for (genvar s = 0; s < NSRC; s++) begin : g_src
      logic [NSTAGE-1:0] hit;
      logic              found;
      logic [1:0]        sel_tnew;
      logic [31:0]       sel_data;

      for (genvar k = 0; k < NSTAGE; k++) begin : g_slot
        assign hit[k] = src_used[s] && slot_valid[k] && (slot_a3[k] != 5'd0)
                        && (slot_a3[k] == src_addr[s]);
      end

      // Scan oldest to youngest so the youngest hit overwrites the selection.
      always_comb begin
        found    = 1'b0;
        sel_tnew = 2'd0;
        sel_data = 32'd0;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
          if (hit[k]) begin
            found    = 1'b1;
            sel_tnew = slot_tnew[k];
            sel_data = stage_data[k];
          end
        end
      end

      assign src_stall[s] = found && (sel_tnew > src_tuse[s]);

      always_comb begin
        if (src_addr[s] == 5'd0)
          src_val[s] = 32'd0;
        else if (found && (sel_tnew == 2'd0))
          src_val[s] = sel_data;
        else
          src_val[s] = src_grf[s];
      end
    end
  endgenerate

  assign stall           = src_stall[0] | src_stall[1];
  assign bus.stall       = stall;
  assign bus.rs_val      = src_val[0];
  assign bus.rt_val      = src_val[1];
  assign bus.stall_count = stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid <= '0;
      for (int k = 0; k < NSTAGE; k++) begin
        slot_a3[k]   <= 5'd0;
        slot_tnew[k] <= 2'd0;
      end
      stall_cnt <= '0;
    end else if (!bus.freeze) begin
      for (int k = NSTAGE - 1; k > 0; k--) begin
        slot_valid[k] <= slot_valid[k-1];
        slot_a3[k]    <= slot_a3[k-1];
        slot_tnew[k]  <= (slot_tnew[k-1] == 2'd0) ? 2'd0 : slot_tnew[k-1] - 2'd1;
      end
      if (bus.issue && !stall) begin
        slot_valid[0] <= 1'b1;
        slot_a3[0]    <= bus.issue_a3;
        slot_tnew[0]  <= bus.issue_tnew;
      end else begin
        slot_valid[0] <= 1'b0;
        slot_a3[0]    <= 5'd0;
        slot_tnew[0]  <= 2'd0;
      end
      if (stall)
        stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reg_read_scoreboard.sv
// +------------------------------------------------------------------+
// | tb_reg_read_scoreboard : directed + random checks vs queue model  |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_reg_read_scoreboard;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  reg_read_scoreboard_if #(.CNTW(32)) bus ();

  reg_read_scoreboard #(.NSTAGE(3), .CNTW(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Model: each issued write remembers how many advancing edges had occurred
  // when it entered E; its stage and remaining latency follow from its age.
  typedef struct {
    logic [4:0] a3;
    int         tnew0;
    int         birth;
  } ent_t;

  ent_t        q[$];
  int          adv;
  logic [31:0] m_cnt;
  int          total;
  int          passed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_src(input logic [4:0] addr, input logic used, input logic [1:0] tuse,
                           input logic [31:0] grf, output logic st, output logic [31:0] val);
    int best_stage;
    int best_tnew;
    best_stage = 99;
    best_tnew  = 0;
    foreach (q[i]) begin
      int stg;
      stg = adv - q[i].birth;
      if (used && q[i].a3 != 0 && q[i].a3 == addr && stg < best_stage) begin
        best_stage = stg;
        best_tnew  = (q[i].tnew0 > stg) ? q[i].tnew0 - stg : 0;
      end
    end
    st = (best_stage != 99) && (best_tnew > int'(tuse));
    if (addr == 0)                             val = 32'd0;
    else if (best_stage == 99 || best_tnew > 0) val = grf;
    else if (best_stage == 0)                  val = bus.fwd_e;
    else if (best_stage == 1)                  val = bus.fwd_m;
    else                                       val = bus.fwd_w;
  endtask

  task automatic model_edge(input logic st);
    if (reset) begin
      q.delete();
      m_cnt = 32'd0;
    end else if (!bus.freeze) begin
      adv++;
      if (st) m_cnt = m_cnt + 32'd1;
      if (bus.issue && !st) q.push_back('{bus.issue_a3, int'(bus.issue_tnew), adv});
      for (int i = q.size() - 1; i >= 0; i--)
        if (adv - q[i].birth > 2) q.delete(i);
    end
  endtask

  task automatic tick();
    logic        s1, s2;
    logic [31:0] v1, v2;
    #1;
    model_src(bus.rs_addr, bus.rs_used, bus.rs_tuse, bus.grf_r1, s1, v1);
    model_src(bus.rt_addr, bus.rt_used, bus.rt_tuse, bus.grf_r2, s2, v2);
    chk("stall", {31'd0, bus.stall}, {31'd0, s1 | s2});
    chk("rs_val", bus.rs_val, v1);
    chk("rt_val", bus.rt_val, v2);
    chk("stall_count", bus.stall_count, m_cnt);
    @(posedge clk);
    model_edge(s1 | s2);
    #1;
  endtask

  task automatic idle();
    bus.freeze   = 1'b0;
    bus.issue    = 1'b0;
    bus.issue_a3 = 5'd0;
    bus.issue_tnew = 2'd0;
    bus.rs_addr  = 5'd0;
    bus.rt_addr  = 5'd0;
    bus.rs_tuse  = 2'd0;
    bus.rt_tuse  = 2'd0;
    bus.rs_used  = 1'b0;
    bus.rt_used  = 1'b0;
    bus.grf_r1   = 32'h1111_0001;
    bus.grf_r2   = 32'h2222_0002;
    bus.fwd_e    = 32'hE0E0_E0E0;
    bus.fwd_m    = 32'hD0D0_D0D0;
    bus.fwd_w    = 32'hC0C0_C0C0;
  endtask

  task automatic do_issue(input logic [4:0] a3, input logic [1:0] tn);
    bus.issue      = 1'b1;
    bus.issue_a3   = a3;
    bus.issue_tnew = tn;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    adv    = 0;
    m_cnt  = 32'd0;
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state, no in-flight writes
    bus.rs_addr = 5'd5; bus.rs_used = 1'b1; bus.rs_tuse = 2'd1;
    #1;
    chk("t1_stall", {31'd0, bus.stall}, 32'd0);
    chk("t1_rs_grf", bus.rs_val, 32'h1111_0001);
    chk("t1_count", bus.stall_count, 32'd0);
    tick();

    // ALU result forwarded from M
    idle(); do_issue(5'd8, 2'd1); tick();
    idle(); bus.rs_addr = 5'd8; bus.rs_used = 1'b1; bus.rs_tuse = 2'd1; bus.fwd_m = 32'h1234;
    #1; chk("t2_nostall", {31'd0, bus.stall}, 32'd0);
    tick();
    #1; chk("t2_fwd_m", bus.rs_val, 32'h1234);
    tick();
    idle(); repeat (3) tick();

    // load-use: one stall cycle for tuse=1
    do_issue(5'd9, 2'd2); tick();
    idle(); bus.rt_addr = 5'd9; bus.rt_used = 1'b1; bus.rt_tuse = 2'd1; do_issue(5'd10, 2'd1);
    #1; chk("t3_stall", {31'd0, bus.stall}, 32'd1);
    tick();
    #1; chk("t3_release", {31'd0, bus.stall}, 32'd0);
    chk("t3_count", bus.stall_count, 32'd1);
    tick();
    idle(); repeat (3) tick();

    // branch after load: two stall cycles, then W forwarding
    do_issue(5'd11, 2'd2); tick();
    idle(); bus.rs_addr = 5'd11; bus.rs_used = 1'b1; bus.rs_tuse = 2'd0; do_issue(5'd14, 2'd1);
    #1; chk("t4_stall1", {31'd0, bus.stall}, 32'd1);
    tick();
    #1; chk("t4_stall2", {31'd0, bus.stall}, 32'd1);
    tick();
    #1; chk("t4_release", {31'd0, bus.stall}, 32'd0);
    chk("t4_fwd_w", bus.rs_val, 32'hC0C0_C0C0);
    chk("t4_count", bus.stall_count, 32'd3);
    tick();
    idle(); repeat (3) tick();

    // youngest match wins; register 0 is never forwarded
    do_issue(5'd3, 2'd0); tick();
    tick();
    idle(); bus.rs_addr = 5'd3; bus.rs_used = 1'b1; bus.rs_tuse = 2'd1;
    bus.fwd_e = 32'hA; bus.fwd_m = 32'hB; do_issue(5'd0, 2'd2);
    #1; chk("t5_youngest", bus.rs_val, 32'hA);
    tick();
    idle(); bus.rs_addr = 5'd0; bus.rs_used = 1'b1; bus.rs_tuse = 2'd0;
    #1; chk("t5_zero_stall", {31'd0, bus.stall}, 32'd0);
    chk("t5_zero_val", bus.rs_val, 32'd0);
    tick();

    // freeze during a load-use stall, then reset under freeze
    idle(); do_issue(5'd12, 2'd2); tick();
    idle(); bus.rt_addr = 5'd12; bus.rt_used = 1'b1; bus.rt_tuse = 2'd1; do_issue(5'd13, 2'd1);
    #1; chk("t6_stall", {31'd0, bus.stall}, 32'd1);
    bus.freeze = 1'b1;
    repeat (4) tick();
    chk("t6_frozen_stall", {31'd0, bus.stall}, 32'd1);
    chk("t6_frozen_count", bus.stall_count, 32'd3);
    bus.freeze = 1'b0;
    tick();
    chk("t6_count", bus.stall_count, 32'd4);
    reset = 1'b1; bus.freeze = 1'b1;
    tick();
    reset = 1'b0; bus.freeze = 1'b0;
    #1; chk("t6_rst_count", bus.stall_count, 32'd0);
    chk("t6_rst_stall", {31'd0, bus.stall}, 32'd0);
    chk("t6_rst_rt", bus.rt_val, 32'h2222_0002);

    // randomized traffic over a small register set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      reset          = ($urandom_range(0, 63) == 0);
      bus.freeze     = ($urandom_range(0, 7) == 0);
      bus.issue      = $urandom_range(0, 1) == 1;
      bus.issue_a3   = 5'($urandom_range(0, 4));
      bus.issue_tnew = 2'($urandom_range(0, 2));
      bus.rs_addr    = 5'($urandom_range(0, 4));
      bus.rt_addr    = 5'($urandom_range(0, 4));
      bus.rs_tuse    = 2'($urandom_range(0, 2));
      bus.rt_tuse    = 2'($urandom_range(0, 2));
      bus.rs_used    = $urandom_range(0, 3) != 0;
      bus.rt_used    = $urandom_range(0, 3) != 0;
      bus.grf_r1     = $urandom;
      bus.grf_r2     = $urandom;
      bus.fwd_e      = $urandom;
      bus.fwd_m      = $urandom;
      bus.fwd_w      = $urandom;
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
